// File: rtl/regfile_pkg.sv
// Shared defaults and control-state encoding for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;
  localparam int BYPASS_DEF   = 1;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read lane: storage mux, entry-0 masking, write bypass and busy lookup.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF
) (
  input  logic                             run,
  input  logic [ADDR_W-1:0]                ra,
  input  logic                             we,
  input  logic [ADDR_W-1:0]                wa,
  input  logic [DATA_W-1:0]                wd,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    mem_flat,
  input  logic [(2**ADDR_W)-1:0]           busy,
  output logic [DATA_W-1:0]                rd,
  output logic                             rd_busy
);

  logic [DATA_W-1:0] stored;
  logic              is_zero;
  logic              fwd;

  always_comb begin
    stored  = mem_flat[int'(ra)*DATA_W +: DATA_W];
    is_zero = (ZERO_REG != 0) && (ra == '0);
    fwd     = (BYPASS != 0) && we && (wa == ra) && !((ZERO_REG != 0) && (wa == '0));
    rd      = '0;
    rd_busy = 1'b0;
    // A forwarded write is also the writeback, so the lane reports not-busy.
    if (run && !is_zero) begin
      if (fwd) begin
        rd = wd;
      end else begin
        rd      = stored;
        rd_busy = busy[ra];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sweep and per-entry busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int BYPASS   = BYPASS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic                    state;
  logic [ADDR_W-1:0]       sweep;
  logic [DEPTH-1:0]        busy;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic                    run;
  logic                    wr_ok;
  logic                    set_ok;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;

  assign run       = (state == ST_RUN) && !rst;
  assign init_done = run;

  always_comb begin
    wr_ok   = we && !((ZERO_REG != 0) && (wa == '0));
    set_ok  = sb_set && !((ZERO_REG != 0) && (sb_addr == '0));
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = wd;
    // Sweep and user writes share one write port so storage stays a simple RAM.
    if (!rst) begin
      if (state == ST_INIT) begin
        wr_en   = 1'b1;
        wr_addr = sweep;
        wr_data = '0;
      end else begin
        wr_en = wr_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      sweep <= '0;
      busy  <= '0;
    end else if (state == ST_INIT) begin
      sweep <= sweep + 1'b1;
      if (sweep == ADDR_W'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end else begin
      // Set is applied after clear so a new producer supersedes the writeback.
      if (we) begin
        busy[wa] <= 1'b0;
      end
      if (set_ok) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_flat
    assign mem_flat[e*DATA_W +: DATA_W] = mem[e];
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .run      (run),
      .ra       (ra[g*ADDR_W +: ADDR_W]),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .mem_flat (mem_flat),
      .busy     (busy),
      .rd       (rd[g*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst;
  logic           init_done;
  logic           we;
  logic [AW-1:0]  wa;
  logic [DW-1:0]  wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic           sb_set;
  logic [AW-1:0]  sb_addr;
  logic [NR-1:0]  rd_busy;

  int total;
  int bad;

  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_busy [DEPTH];
  logic          ref_run;
  int            init_left;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .ra        (ra),
    .rd        (rd),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .rd_busy   (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst || !ref_run || a == 0) return '0;
    if (we && wa == a) return wd;
    return ref_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (rst || !ref_run || a == 0) return 1'b0;
    if (we && wa == a) return 1'b0;
    return ref_busy[a];
  endfunction

  // Advance one clock edge, applying the architectural effect of the current inputs.
  task automatic tick();
    if (rst) begin
      ref_run   = 1'b0;
      init_left = DEPTH;
      foreach (ref_busy[j]) ref_busy[j] = 1'b0;
    end else if (!ref_run) begin
      init_left--;
      if (init_left == 0) begin
        ref_run = 1'b1;
        foreach (ref_mem[j]) ref_mem[j] = '0;
      end
    end else begin
      if (we && wa != 0) ref_mem[wa] = wd;
      if (we) ref_busy[wa] = 1'b0;
      if (sb_set && sb_addr != 0) ref_busy[sb_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0; ra = '0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] a;
    idle_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (init_done !== 1'b0 || rd !== '0 || rd_busy !== '0) begin
      bad++;
      $display("FAIL reset_hold: init_done=%b rd=%h rd_busy=%b want 0/0/0", init_done, rd, rd_busy);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      we = 1'($urandom); wa = AW'($urandom); wd = $urandom;
      sb_set = 1'($urandom); sb_addr = AW'($urandom); ra = NR*AW'($urandom);
      #1;
      total++;
      if (init_done !== 1'b0) begin
        bad++;
        $display("FAIL sweep_init_done cyc=%0d: got %b want 0", k, init_done);
      end
      total++;
      if (rd !== '0 || rd_busy !== '0) begin
        bad++;
        $display("FAIL sweep_outputs cyc=%0d: rd=%h rd_busy=%b want 0", k, rd, rd_busy);
      end
      tick();
    end
    idle_inputs();
    #1;
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_done_rise: got %b want 1", init_done);
    end
    for (int e = 0; e < DEPTH; e += NR) begin
      for (int i = 0; i < NR; i++) ra[i*AW +: AW] = AW'(e + i);
      #1;
      for (int i = 0; i < NR; i++) begin
        a = ra[i*AW +: AW];
        total++;
        if (rd[i*DW +: DW] !== 32'h0 || rd[i*DW +: DW] !== exp_rd(a)) begin
          bad++;
          $display("FAIL post_init_zero entry=%0d: got %h want 0", a, rd[i*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    ra[0 +: AW] = 5'd5; ra[AW +: AW] = 5'd6;
    #1;
    total++;
    if (rd[0 +: DW] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_same_cycle: got %h want deadbeef", rd[0 +: DW]);
    end
    total++;
    if (rd[DW +: DW] !== exp_rd(5'd6)) begin
      bad++;
      $display("FAIL bypass_other_lane: got %h want %h", rd[DW +: DW], exp_rd(5'd6));
    end
    tick();
    we = 1'b0; wd = '0;
    #1;
    total++;
    if (rd[0 +: DW] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL bypass_committed: got %h want deadbeef", rd[0 +: DW]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we = 1'b1; wa = '0; wd = 32'h12345678;
    sb_set = 1'b1; sb_addr = '0;
    ra = '0;
    #1;
    total++;
    if (rd !== '0 || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL zero_reg_fwd: rd=%h rd_busy=%b want 0/00", rd, rd_busy);
    end
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    total++;
    if (rd !== '0 || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL zero_reg_after: rd=%h rd_busy=%b want 0/00", rd, rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    sb_set = 1'b1; sb_addr = 5'd7;
    tick();
    sb_set = 1'b0;
    ra[AW +: AW] = 5'd7;
    ra[0 +: AW]  = 5'd7;
    #1;
    total++;
    if (rd_busy !== 2'b11) begin
      bad++;
      $display("FAIL sb_busy_set: rd_busy=%b want 11", rd_busy);
    end
    we = 1'b1; wa = 5'd7; wd = 32'h55;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0 || rd[DW +: DW] !== 32'h55) begin
      bad++;
      $display("FAIL sb_writeback_fwd: busy1=%b rd1=%h want 0/00000055", rd_busy[1], rd[DW +: DW]);
    end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rd_busy !== 2'b00 || rd[0 +: DW] !== 32'h55 || rd[DW +: DW] !== 32'h55) begin
      bad++;
      $display("FAIL sb_cleared: rd_busy=%b rd=%h want 00 / 55 on both lanes", rd_busy, rd);
    end
  endtask

  task automatic test_set_wins();
    idle_inputs();
    sb_set = 1'b1; sb_addr = 5'd9;
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5_0009;
    tick();
    idle_inputs();
    ra[0 +: AW] = 5'd9;
    #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_busy: got %b want 1", rd_busy[0]);
    end
    total++;
    if (rd[0 +: DW] !== 32'hA5A5_0009) begin
      bad++;
      $display("FAIL set_wins_data: got %h want a5a50009", rd[0 +: DW]);
    end
  endtask

  task automatic test_reset_midsweep();
    idle_inputs();
    we = 1'b1; wa = 5'd3; wd = 32'hCAFE_0003;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      total++;
      if (init_done !== 1'b0) begin
        bad++;
        $display("FAIL midsweep_init_done cyc=%0d: got %b want 0", k, init_done);
      end
      tick();
    end
    ra[0 +: AW] = 5'd3; ra[AW +: AW] = 5'd9;
    #1;
    total++;
    if (init_done !== 1'b1) begin
      bad++;
      $display("FAIL midsweep_done: got %b want 1", init_done);
    end
    total++;
    if (rd[0 +: DW] !== 32'h0 || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL midsweep_cleared: rd0=%h rd_busy=%b want 0/00", rd[0 +: DW], rd_busy);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 500; c++) begin
      we = ($urandom_range(0, 2) != 0);
      wa = AW'($urandom_range(0, 11));
      wd = $urandom;
      sb_set = ($urandom_range(0, 3) == 0);
      sb_addr = AW'($urandom_range(0, 11));
      for (int i = 0; i < NR; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) ra[AW +: AW] = ra[0 +: AW];
      #1;
      for (int i = 0; i < NR; i++) begin
        a = ra[i*AW +: AW];
        total++;
        if (rd[i*DW +: DW] !== exp_rd(a)) begin
          bad++;
          $display("FAIL rand_rd c=%0d lane=%0d addr=%0d: got %h want %h", c, i, a, rd[i*DW +: DW], exp_rd(a));
        end
        total++;
        if (rd_busy[i] !== exp_busy(a)) begin
          bad++;
          $display("FAIL rand_busy c=%0d lane=%0d addr=%0d: got %b want %b", c, i, a, rd_busy[i], exp_busy(a));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    ref_run = 1'b0;
    init_left = DEPTH;
    foreach (ref_mem[j]) ref_mem[j] = '0;
    foreach (ref_busy[j]) ref_busy[j] = 1'b0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_wins();
    test_random();
    test_reset_midsweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, width of each register entry, SHALL be supported from 8 to 64.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports, SHALL be supported from 1 to 4.
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 SHALL read as zero and ignore writes.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle write SHALL be forwarded to matching read ports (write-first).
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 init_done  output  1  high once the post-reset clear sweep has finished.
REQ-009 we  input  1  write enable, also the writeback that clears the scoreboard entry.
REQ-010 wa  input  ADDR_W  write address.
REQ-011 wd  input  DATA_W  write data.
REQ-012 ra  input  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-013 rd  output  NUM_RD*DATA_W  packed read data, same packing as ra.
REQ-014 sb_set  input  1  marks entry sb_addr busy (a producer instruction has been issued).
REQ-015 sb_addr  input  ADDR_W  scoreboard set address.
REQ-016 rd_busy  output  NUM_RD  per-port flag: the addressed entry has a pending writeback.

Function
REQ-017 Reads SHALL be combinational (zero-cycle latency); writes SHALL take effect at the next rising clk edge.
REQ-018 The control FSM SHALL have two states, INIT and RUN; rst SHALL force INIT with the sweep counter at 0.
REQ-019 In INIT, one entry per cycle (addresses 0 to DEPTH-1) SHALL be written to zero; after entry DEPTH-1 is written, the FSM SHALL enter RUN on the next edge, so init_done rises exactly DEPTH cycles after rst deasserts.
REQ-020 In INIT, we and sb_set SHALL be ignored, all rd lanes SHALL read 0, and all rd_busy bits SHALL be 0.
REQ-021 In RUN, we=1 SHALL write wd to entry wa, except for wa=0 when ZERO_REG=1.
REQ-022 When BYPASS=1, we=1 and wa equals ra[i], lane i SHALL return wd in the same cycle; this forwarding SHALL NOT apply to wa=0 when ZERO_REG=1.
REQ-023 When BYPASS=0, lane i SHALL return the stored value until the edge that commits the write.
REQ-024 When ZERO_REG=1, any lane addressing entry 0 SHALL return 0 and its rd_busy bit SHALL be 0.
REQ-025 Scoreboard: DEPTH busy bits; sb_set SHALL set busy[sb_addr], and we SHALL clear busy[wa] at the next edge.
REQ-026 If sb_set and we target the same address in the same cycle, set SHALL win, because a new producer supersedes the old one.
REQ-027 sb_set to entry 0 SHALL be ignored when ZERO_REG=1.
REQ-028 rd_busy[i] SHALL equal busy[ra[i]], forced to 0 when BYPASS=1 and a same-cycle write to ra[i] is forwarded.
REQ-029 Multiple read ports addressing the same entry SHALL return identical data and busy flags.

Reset
REQ-030 rst SHALL take priority over all inputs; while rst is high, init_done=0, rd=0 and rd_busy=0.
REQ-031 rst asserted mid-sweep or in RUN SHALL restart the sweep at address 0 and clear all busy bits.
REQ-032 Register contents are undefined only until the sweep reaches them, and SHALL never be observable in that state because rd is forced to 0 in INIT.

Structure
REQ-033 Package regfile_pkg SHALL hold the default parameter values and the INIT/RUN state encoding.
REQ-034 Storage SHALL map to distributed RAM, not block RAM, so that reads stay combinational.
REQ-035 One sub-module, regfile_rd_port, SHALL implement a single read lane (storage mux, zero-register masking, bypass, busy lookup); the top SHALL instantiate it NUM_RD times through a generate loop.

Verification
REQ-036 Pulse rst for 1 cycle, then release -> init_done=0 for 32 cycles and 1 on the 33rd; every entry then reads 0.
REQ-037 In RUN, write wa=5, wd=0xDEADBEEF with ra[0]=5 in the same cycle -> lane 0 shows 0xDEADBEEF combinationally (BYPASS=1), or the old 0 until the edge (BYPASS=0).
REQ-038 Write wa=0, wd=0x12345678, then read entry 0 on both lanes -> both return 0 and rd_busy=00.
REQ-039 sb_set with sb_addr=7; next cycle ra[1]=7 -> rd_busy[1]=1; then we with wa=7, wd=0x55 and the same ra -> rd_busy[1]=0 and rd lane 1 = 0x55 in that cycle.
REQ-040 sb_set and we both targeting address 9 in the same cycle -> busy[9] is 1 after the edge.
REQ-041 Assert rst at sweep count 10 -> init_done stays 0 for a further 32 cycles after release, and a prior write to entry 3 reads 0 afterwards.
